cbs_conv_scheduler: RTL and testbench

- Single-clock sequencer for the CBS 3x3 convolution datapath. It replaces the ripple-clocked column, row, tap and filter counters with one synchronous controller.
- Walks filter, then output row, then output column. For every output pixel it issues the 9 image-tap addresses with zero-padding flags, plus the matching filter-coefficient addresses.
- Aligns a data-valid strobe to the memory read latency, then hands one window to the convolution engine per valid/ready handshake.
- Sits between the image/filter memories and the 9-tap window storage/convolution engine.

---
 rtl/cbs_pkg.sv | 8 +
 rtl/cbs_conv_scheduler_valid_pipe.sv | 20 ++
 rtl/cbs_conv_scheduler.sv | 116 +++++++++++
 tb/tb_cbs_conv_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// cbs_pkg: shared state encoding and 3x3 tap geometry for the conv scheduler
package cbs_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ISSUE, DONE} state_t;
  localparam int TAPS = 9;
  // row/col offset of each tap biased by +1: 0 is -1, 1 is 0, 2 is +1
  localparam logic [1:0] TAP_DR [TAPS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
  localparam logic [1:0] TAP_DC [TAPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
endpackage

// File: rtl/cbs_conv_scheduler_valid_pipe.sv
// cbs_valid_pipe: delays the {valid, tap, pad} read-slot tag by the memory read latency
module cbs_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] d,
  output logic [5:0] q
);
  logic [5:0] stage [LAT];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = stage[LAT-1];
endmodule

// File: rtl/cbs_conv_scheduler.sv
// cbs_conv_scheduler: sequences tap reads and window handoff for the 3x3 convolution datapath
module cbs_conv_scheduler
  import cbs_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 640,
  parameter int NUM_FILT = 24,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 19,
  parameter int FADDR_W  = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               img_rd_en,
  output logic [ADDR_W-1:0]  img_addr,
  output logic               filt_rd_en,
  output logic [FADDR_W-1:0] filt_addr,
  output logic               data_valid,
  output logic [3:0]         data_tap,
  output logic               data_pad,
  output logic               win_valid,
  input  logic               conv_ready,
  output logic [14:0]        out_row,
  output logic [14:0]        out_col,
  output logic [4:0]         out_filt
);
  localparam logic [14:0]        COL_LAST  = 15'(IMG_W - 1);
  localparam logic [14:0]        ROW_LAST  = 15'(IMG_H - 1);
  localparam logic [4:0]         FILT_LAST = 5'(NUM_FILT - 1);
  localparam logic [3:0]         TAP_LAST  = 4'(TAPS - 1);
  localparam logic [2:0]         LAT_LAST  = 3'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0]  W_STEP    = ADDR_W'(IMG_W);
  localparam logic [FADDR_W-1:0] F_STEP    = FADDR_W'(TAPS);

  state_t             state;
  logic [3:0]         tap;
  logic [2:0]         lat_cnt;
  logic [ADDR_W-1:0]  row_base;
  logic [FADDR_W-1:0] filt_base;
  logic [1:0]         dr, dc;
  logic               fetch, pad, last_col, last_row, last_filt;
  logic [ADDR_W-1:0]  row_off, col_off, tap_addr;

  assign fetch     = state == FETCH;
  assign last_col  = out_col == COL_LAST;
  assign last_row  = out_row == ROW_LAST;
  assign last_filt = out_filt == FILT_LAST;
  assign dr        = TAP_DR[tap];
  assign dc        = TAP_DC[tap];
  assign pad       = (dr == 2'd0 && out_row == '0) || (dr == 2'd2 && last_row) ||
                     (dc == 2'd0 && out_col == '0) || (dc == 2'd2 && last_col);
  // modular arithmetic is exact here because padded taps never reach the port
  assign row_off   = dr == 2'd0 ? -W_STEP : dr == 2'd2 ? W_STEP : '0;
  assign col_off   = dc == 2'd0 ? '1 : dc == 2'd2 ? ADDR_W'(1) : '0;
  assign tap_addr  = row_base + row_off + ADDR_W'(out_col) + col_off;

  assign img_rd_en  = fetch && !pad;
  assign img_addr   = img_rd_en ? tap_addr : '0;
  assign filt_rd_en = fetch;
  assign filt_addr  = fetch ? filt_base + FADDR_W'(tap) : '0;
  assign busy       = state inside {FETCH, DRAIN, ISSUE};
  assign done       = state == DONE;
  assign win_valid  = state == ISSUE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tap       <= '0;
      lat_cnt   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_filt  <= '0;
      row_base  <= '0;
      filt_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          tap   <= '0;
          state <= start ? FETCH : IDLE;
        end
        FETCH: begin
          lat_cnt <= '0;
          tap     <= tap == TAP_LAST ? '0 : tap + 4'd1;
          state   <= tap == TAP_LAST ? DRAIN : FETCH;
        end
        DRAIN: begin
          lat_cnt <= lat_cnt + 3'd1;
          state   <= lat_cnt == LAT_LAST ? ISSUE : DRAIN;
        end
        ISSUE: if (conv_ready) begin
          out_col <= last_col ? '0 : out_col + 15'd1;
          if (last_col) begin
            out_row  <= last_row ? '0 : out_row + 15'd1;
            row_base <= last_row ? '0 : row_base + W_STEP;
          end
          if (last_col && last_row) begin
            out_filt  <= last_filt ? '0 : out_filt + 5'd1;
            filt_base <= last_filt ? '0 : filt_base + F_STEP;
          end
          state <= last_col && last_row && last_filt ? DONE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cbs_valid_pipe #(.LAT(MEM_LAT)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .d     ({fetch, tap, fetch && pad}),
    .q     ({data_valid, data_tap, data_pad})
  );
endmodule

// File: tb/tb_cbs_conv_scheduler.sv
// tb_cbs_conv_scheduler: scoreboard bench on a 4x3 image with 2 filters
module tb_cbs_conv_scheduler;
  localparam int W = 4, H = 3, NF = 2, LAT = 1, AW = 4, FW = 5;
  localparam int NWIN = W * H * NF;

  logic clk = 0, reset = 1, start = 0, conv_ready = 1;
  logic busy, done, img_rd_en, filt_rd_en, data_valid, data_pad, win_valid;
  logic [AW-1:0] img_addr;
  logic [FW-1:0] filt_addr;
  logic [3:0] data_tap;
  logic [14:0] out_row, out_col;
  logic [4:0] out_filt;

  typedef struct packed {logic en; logic [AW-1:0] addr; logic [FW-1:0] faddr;} rd_t;
  rd_t rd_q[$];
  logic [4:0] dv_q[$];
  logic [34:0] win_q[$];
  rd_t cap [NWIN*9];

  int total = 0, bad = 0, cyc = 0, hs_cnt = 0, dv_cnt = 0, done_cnt = 0;
  int hs_cyc = 0, done_cyc = 0, cap_n = 0;
  bit cap_on = 0, tp_on = 0, have_prev = 0;

  // hand-computed reads: window index, tap, en, img_addr, filt_addr
  int hw[15] = '{0, 0, 0, 0, 0, 0, 5, 5, 5, 12, 23, 23, 23, 23, 23};
  int ht[15] = '{0, 3, 4, 5, 7, 8, 0, 4, 8, 4, 0, 2, 4, 5, 8};
  int he[15] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
  int ha[15] = '{0, 0, 0, 1, 4, 5, 0, 5, 10, 0, 6, 0, 11, 0, 0};
  int hf[15] = '{0, 3, 4, 5, 7, 8, 0, 4, 8, 13, 9, 11, 13, 14, 17};

  cbs_conv_scheduler #(
    .IMG_W(W), .IMG_H(H), .NUM_FILT(NF), .MEM_LAT(LAT), .ADDR_W(AW), .FADDR_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .filt_rd_en(filt_rd_en), .filt_addr(filt_addr),
    .data_valid(data_valid), .data_tap(data_tap), .data_pad(data_pad),
    .win_valid(win_valid), .conv_ready(conv_ready),
    .out_row(out_row), .out_col(out_col), .out_filt(out_filt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [54:0] all_outs();
    return {busy, done, img_rd_en, img_addr, filt_rd_en, filt_addr, data_valid, data_tap,
            data_pad, win_valid, out_row, out_col, out_filt};
  endfunction

  task automatic push_pass();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          win_q.push_back({15'(r), 15'(c), 5'(f)});
          for (int t = 0; t < 9; t++) begin
            int rr = r + t / 3 - 1;
            int cc = c + t % 3 - 1;
            bit p = rr < 0 || rr >= H || cc < 0 || cc >= W;
            rd_q.push_back({!p, p ? AW'(0) : AW'(rr * W + cc), FW'(f * 9 + t)});
            dv_q.push_back({4'(t), p});
          end
        end
  endtask

  task automatic start_pass();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < 600) begin @(negedge clk); i++; end
    chk({nm, "_timeout"}, done_cnt == d0, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_leftover"}, {32'(rd_q.size()), 32'(win_q.size() + dv_q.size())}, 0);
  endtask

  always @(negedge clk) if (!reset) begin
    if (filt_rd_en) begin
      if (cap_on && cap_n < NWIN * 9) begin cap[cap_n] = {img_rd_en, img_addr, filt_addr}; cap_n++; end
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd", {img_rd_en, img_addr, filt_addr}, rd_q.pop_front());
    end else if (img_rd_en) chk("rd_orphan", 1, 0);
    if (data_valid) begin
      dv_cnt++;
      if (dv_q.size() == 0) chk("dv_unexpected", 1, 0);
      else chk("dv", {data_tap, data_pad}, dv_q.pop_front());
    end
    if (win_valid && conv_ready) begin
      if (win_q.size() == 0) chk("win_unexpected", 1, 0);
      else chk("win", {out_row, out_col, out_filt}, win_q.pop_front());
      if (tp_on && have_prev) chk("interval", cyc - hs_cyc, 9 + LAT + 1);
      have_prev = tp_on;
      hs_cyc = cyc;
      hs_cnt++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  initial begin
    int h0, d0, v0, i;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("reset_hold", all_outs(), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk) chk("idle_outs", all_outs(), 0);

    // full pass, conv_ready tied high, stray start while busy
    h0 = hs_cnt; d0 = done_cnt; v0 = dv_cnt;
    push_pass(); cap_on = 1; tp_on = 1;
    start_pass();
    repeat (30) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done("pass1");
    cap_on = 0; tp_on = 0;
    chk("pass1_windows", hs_cnt - h0, NWIN);
    chk("pass1_dv_count", dv_cnt - v0, NWIN * 9);
    chk("pass1_done_once", done_cnt - d0, 1);
    chk("pass1_done_lag", done_cyc - hs_cyc, 1);
    chk("pass1_idle", {busy, done, win_valid}, 0);
    chk_empty("pass1");
    for (int k = 0; k < 15; k++)
      chk($sformatf("hand_w%0d_t%0d", hw[k], ht[k]), cap[hw[k] * 9 + ht[k]],
          {1'(he[k]), AW'(ha[k]), FW'(hf[k])});

    // stall the first window in ISSUE for 20 cycles
    h0 = hs_cnt; d0 = done_cnt;
    conv_ready = 0;
    push_pass();
    start_pass();
    i = 0;
    while (!win_valid && i < 50) begin @(negedge clk); i++; end
    chk("stall_reach", win_valid, 1);
    repeat (20) begin
      @(negedge clk);
      chk("stall_hold", {win_valid, filt_rd_en, img_rd_en, busy, out_row, out_col, out_filt},
          {4'b1001, 35'd0});
    end
    @(posedge clk); #1 conv_ready = 1;
    @(negedge clk);
    @(negedge clk) chk("stall_advance", {filt_rd_en, out_row, out_col}, {1'b1, 15'd0, 15'd1});
    wait_done("pass2");
    chk("pass2_windows", hs_cnt - h0, NWIN);
    chk("pass2_done_once", done_cnt - d0, 1);
    chk_empty("pass2");

    // reset in the middle of window 5's fetch
    h0 = hs_cnt; d0 = done_cnt;
    push_pass();
    start_pass();
    i = 0;
    while (hs_cnt - h0 < 5 && i < 200) begin @(negedge clk); i++; end
    chk("reach_w5", hs_cnt - h0, 5);
    @(posedge clk); #1;
    @(negedge clk) chk("w5_fetching", {filt_rd_en, out_col}, {1'b1, 15'd1});
    @(posedge clk); #1 reset = 1;
    rd_q.delete(); dv_q.delete(); win_q.delete();
    @(posedge clk); #1 reset = 0;
    @(negedge clk) chk("post_reset_outs", all_outs(), 0);
    repeat (15) @(negedge clk);
    chk("abandon_no_done", done_cnt - d0, 0);
    chk("abandon_idle", {busy, win_valid}, 0);

    // fresh pass after the abandoned one starts at window (0,0,0)
    h0 = hs_cnt; d0 = done_cnt;
    push_pass();
    start_pass();
    wait_done("pass4");
    chk("pass4_windows", hs_cnt - h0, NWIN);
    chk("pass4_done_once", done_cnt - d0, 1);
    chk_empty("pass4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
